// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP feeder: the payload word, the feeder
// state encoding and the skid buffer depth.
package mlp_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_WAIT_RES
  } feeder_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/mlp_skid_buf.sv
// Two-entry FIFO between the host stream and the core handshakes. The input
// ready is a flop (low during reset) so host backpressure never sees core ready.
module mlp_skid_buf
  import mlp_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  word_t in_data_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output word_t out_data_o
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  word_t            mem_q [SKID_DEPTH];
  word_t            mem_d [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             push, pop;

  assign push        = in_valid_i & rdy_q;
  assign out_valid_o = (cnt_q != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = rdy_q;
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data_i;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rdy_d    = (cnt_d != CNT_W'(SKID_DEPTH));
  end

  // Data storage is reset too so the payload bus reads zero while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

endmodule

// File: rtl/mlp_feeder.sv
// Host word stream to MLP core init/start handshakes: NUM_W weight words, then
// NUM_X-word input vectors gated by result pulses. Optional watchdog: MLP_FEEDER_TIMEOUT_EN.
module mlp_feeder
  import mlp_pkg::*;
#(
  parameter int NUM_W   = 16,
  parameter int NUM_X   = 4,
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [15:0]      s_data_i,
  input  logic             reload_i,
  output logic             init_valid_o,
  input  logic             init_ready_i,
  output logic             start_valid_o,
  input  logic             start_ready_i,
  output logic [15:0]      load_payload_o,
  input  logic             result_valid_i,
  output logic             weights_loaded_o,
  output logic [CNT_W-1:0] infer_count_o,
  output logic             err_o
);

  localparam int WC_W = $clog2(NUM_W + 1);
  localparam int XC_W = $clog2(NUM_X + 1);

  feeder_state_e    state_q, state_d;
  logic [WC_W-1:0]  w_cnt_q, w_cnt_d;
  logic [XC_W-1:0]  x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] infer_q, infer_d;
  logic             wl_q, wl_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             inflight_q, inflight_d;
  logic             hold_q, hold_d;
  logic             head_vld, pop, take_rld;
  word_t            head;
`ifdef MLP_FEEDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  mlp_skid_buf u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (s_valid_i),
    .in_ready_o  (s_ready_o),
    .in_data_i   (s_data_i),
    .out_valid_o (head_vld),
    .out_ready_i (pop),
    .out_data_o  (head)
  );

  // A reload may only cut in at a vector boundary before start_valid_o has been shown.
  assign take_rld = (reload_i | pend_q) & (x_cnt_q == '0) & ~inflight_q;
  assign pop      = (init_valid_o & init_ready_i) | (start_valid_o & start_ready_i);

  always_comb begin
    state_d       = state_q;
    w_cnt_d       = w_cnt_q;
    x_cnt_d       = x_cnt_q;
    infer_d       = infer_q;
    wl_d          = wl_q;
    pend_d        = pend_q;
    err_d         = err_q;
    inflight_d    = 1'b0;
    hold_d        = s_valid_i & ~s_ready_o;
    init_valid_o  = 1'b0;
    start_valid_o = 1'b0;
`ifdef MLP_FEEDER_TIMEOUT_EN
    tmo_d         = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (reload_i) begin
          state_d = S_LOAD_W;
          wl_d    = 1'b0;
          w_cnt_d = '0;
          pend_d  = 1'b0;
        end else if (head_vld) begin
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        init_valid_o = head_vld;
        if (reload_i) pend_d = 1'b1;
        if (head_vld && init_ready_i) begin
          if (w_cnt_q == WC_W'(NUM_W - 1)) begin
            wl_d    = 1'b1;
            w_cnt_d = '0;
            state_d = S_LOAD_X;
          end else begin
            w_cnt_d = w_cnt_q + WC_W'(1);
          end
        end
      end
      S_LOAD_X: begin
        if (take_rld) begin
          state_d = S_LOAD_W;
          wl_d    = 1'b0;
          w_cnt_d = '0;
          pend_d  = 1'b0;
        end else begin
          if (reload_i) pend_d = 1'b1;
          start_valid_o = head_vld;
          inflight_d    = head_vld & ~start_ready_i;
          if (head_vld && start_ready_i) begin
            if (x_cnt_q == XC_W'(NUM_X - 1)) begin
              x_cnt_d = '0;
              state_d = S_WAIT_RES;
            end else begin
              x_cnt_d = x_cnt_q + XC_W'(1);
            end
          end
        end
      end
      S_WAIT_RES: begin
        if (reload_i) pend_d = 1'b1;
        if (result_valid_i) begin
          infer_d = infer_q + CNT_W'(1);
          state_d = S_LOAD_X;
        end
`ifdef MLP_FEEDER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_LOAD_X;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (result_valid_i && state_q != S_WAIT_RES) err_d = 1'b1;
    if (hold_q && !s_valid_i) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      w_cnt_q    <= '0;
      x_cnt_q    <= '0;
      infer_q    <= '0;
      wl_q       <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      hold_q     <= 1'b0;
`ifdef MLP_FEEDER_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      w_cnt_q    <= w_cnt_d;
      x_cnt_q    <= x_cnt_d;
      infer_q    <= infer_d;
      wl_q       <= wl_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      hold_q     <= hold_d;
`ifdef MLP_FEEDER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign load_payload_o   = head;
  assign weights_loaded_o = wl_q;
  assign infer_count_o    = infer_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_mlp_feeder.sv
// Directed bench for mlp_feeder (NUM_W=4, NUM_X=2): host words carry their
// expected core-side kind; a scoreboard queue checks every core handshake.
module tb_mlp_feeder;

  typedef struct {
    logic        kind;  // 0 = init (weight), 1 = start (input)
    logic [15:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready_o;
  logic [15:0] s_data;
  logic        reload;
  logic        init_valid_o;
  logic        init_ready;
  logic        start_valid_o;
  logic        start_ready;
  logic [15:0] load_payload_o;
  logic        result;
  logic        weights_loaded_o;
  logic [15:0] infer_count_o;
  logic        err_o;

  item_t host_q[$];
  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic        hold_init, hold_start;
  logic [15:0] hold_pl;

  mlp_feeder #(.NUM_W(4), .NUM_X(2), .CNT_W(16), .TMO_CYC(1024)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready_o),
    .s_data_i         (s_data),
    .reload_i         (reload),
    .init_valid_o     (init_valid_o),
    .init_ready_i     (init_ready),
    .start_valid_o    (start_valid_o),
    .start_ready_i    (start_ready),
    .load_payload_o   (load_payload_o),
    .result_valid_i   (result),
    .weights_loaded_o (weights_loaded_o),
    .infer_count_o    (infer_count_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic enq(input logic kind, input logic [15:0] data);
    item_t it;
    it.kind = kind;
    it.data = data;
    host_q.push_back(it);
  endtask

  task automatic score(input logic kind);
    item_t it;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL hs_unexpected: observed kind %0d payload %0h expected no handshake", kind, load_payload_o);
    end
    if (exp_q.size() != 0) begin
      it = exp_q.pop_front();
      chk("hs_kind", 32'(kind), 32'(it.kind));
      chk("hs_data", 32'(load_payload_o), 32'(it.data));
    end
  endtask

  // One clock: drive host, sample #1 later, score the handshakes of the coming edge.
  task automatic tick();
    s_valid = (host_q.size() != 0);
    s_data  = s_valid ? host_q[0].data : 16'h0000;
    #1;
    if (rst_n) begin
      if (hold_init)  chk("init_stable",  32'({init_valid_o, load_payload_o}),  32'({1'b1, hold_pl}));
      if (hold_start) chk("start_stable", 32'({start_valid_o, load_payload_o}), 32'({1'b1, hold_pl}));
      chk("valid_excl", 32'(init_valid_o & start_valid_o), 32'(0));
      if (init_valid_o && init_ready)   score(1'b0);
      if (start_valid_o && start_ready) score(1'b1);
      if (s_valid && s_ready_o) exp_q.push_back(host_q.pop_front());
      hold_init  = init_valid_o & ~init_ready;
      hold_start = start_valid_o & ~start_ready;
      hold_pl    = load_payload_o;
    end else begin
      hold_init  = 1'b0;
      hold_start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((host_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(host_q.size() + exp_q.size()), 32'(0));
  endtask

  initial begin
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_data      = 16'h0000;
    reload      = 1'b0;
    init_ready  = 1'b1;
    start_ready = 1'b1;
    result      = 1'b0;
    hold_init   = 1'b0;
    hold_start  = 1'b0;
    hold_pl     = 16'h0000;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_outs", 32'({s_ready_o, init_valid_o, start_valid_o, weights_loaded_o, err_o, load_payload_o}), 32'(0));
    chk("rst_count", 32'(infer_count_o), 32'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    chk("ready_after_rst", 32'(s_ready_o), 32'(1));

    // Session load: four weights then one input vector.
    for (int i = 1; i <= 4; i++) enq(1'b0, 16'(i));
    enq(1'b1, 16'h0005);
    enq(1'b1, 16'h0006);
    drain("session_drain", 60);
    chk("wl_after_session", 32'(weights_loaded_o), 32'(1));
    chk("count_after_session", 32'(infer_count_o), 32'(0));

    // Next vector must wait for the result pulse.
    enq(1'b1, 16'h0007);
    enq(1'b1, 16'h0008);
    repeat (8) tick();
    chk("wait_buffered", 32'(exp_q.size()), 32'(2));
    chk("wait_no_start", 32'(start_valid_o), 32'(0));
    result = 1'b1;
    tick();
    result = 1'b0;
    chk("infer_1", 32'(infer_count_o), 32'(1));
    drain("vector2_drain", 20);

    // Reload requested while waiting, with the core refusing weights.
    reload = 1'b1;
    tick();
    reload     = 1'b0;
    init_ready = 1'b0;
    for (int i = 9; i <= 12; i++) enq(1'b0, 16'(i));
    repeat (6) tick();
    chk("bp_sready_low", 32'(s_ready_o), 32'(0));
    chk("bp_buffered", 32'(exp_q.size()), 32'(2));
    result = 1'b1;
    tick();
    result = 1'b0;
    chk("infer_2", 32'(infer_count_o), 32'(2));
    repeat (2) tick();
    chk("wl_cleared", 32'(weights_loaded_o), 32'(0));
    chk("bp_init_valid", 32'(init_valid_o), 32'(1));
    chk("bp_payload", 32'(load_payload_o), 32'h0009);
    chk("err_clear", 32'(err_o), 32'(0));

    // Spurious result while loading weights.
    result = 1'b1;
    tick();
    result = 1'b0;
    chk("err_set", 32'(err_o), 32'(1));
    chk("infer_kept_spurious", 32'(infer_count_o), 32'(2));
    repeat (2) tick();
    chk("err_sticky", 32'(err_o), 32'(1));
    init_ready = 1'b1;
    drain("reload_drain", 40);
    chk("wl_reloaded", 32'(weights_loaded_o), 32'(1));
    chk("infer_kept_reload", 32'(infer_count_o), 32'(2));

    // Reset in the middle of a vector.
    enq(1'b1, 16'h000D);
    drain("one_start_drain", 20);
    start_ready = 1'b0;
    enq(1'b1, 16'h000E);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({s_ready_o, init_valid_o, start_valid_o, weights_loaded_o, err_o, load_payload_o}), 32'(0));
    chk("midrst_count", 32'(infer_count_o), 32'(0));
    host_q.delete();
    exp_q.delete();
    hold_init  = 1'b0;
    hold_start = 1'b0;
    @(negedge clk);
    start_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    enq(1'b0, 16'h0015);
    drain("post_rst_drain", 30);
    chk("post_rst_wl", 32'(weights_loaded_o), 32'(0));
    chk("post_rst_err", 32'(err_o), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
